// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, FSM encoding, S-box, rcon and word helpers.
package aes_pkg;

  localparam int unsigned NR_AES128 = 10;
  localparam int unsigned BLK_W     = 128;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned RND_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } aes_fsm_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_BITS = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_BITS[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [RND_W-1:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/enc_round.sv
// One full AES encryption round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module enc_round
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  input  logic [BLK_W-1:0] round_key,
  output logic [BLK_W-1:0] result_c
);

  logic [BLK_W-1:0] sb_c;
  logic [BLK_W-1:0] sr_c;
  logic [BLK_W-1:0] mc_c;

  sub_bytes u_sb (.state(state), .result_c(sb_c));
  shift_rows u_sr (.state(sb_c), .result_c(sr_c));

  // MixColumns: each column multiplied by the circulant {02,03,01,01}.
  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr_c[BLK_W-1-32*c      -: 8];
    assign a1 = sr_c[BLK_W-1-32*c-8    -: 8];
    assign a2 = sr_c[BLK_W-1-32*c-16   -: 8];
    assign a3 = sr_c[BLK_W-1-32*c-24   -: 8];
    assign mc_c[BLK_W-1-32*c    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc_c[BLK_W-1-32*c-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc_c[BLK_W-1-32*c-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc_c[BLK_W-1-32*c-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign result_c = mc_c ^ round_key;

endmodule

// File: rtl/key_expand_step.sv
// One AES-128 key-schedule step: current round key plus rcon gives the next round key.
module key_expand_step
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] round_key,
  input  logic [7:0]       rc,
  output logic [BLK_W-1:0] next_key_c
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = round_key;

  assign n0 = w0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key_c = {n0, n1, n2, n3};

endmodule

// File: rtl/shift_rows.sv
// ShiftRows: row r of the column-major state rotates left by r bytes.
module shift_rows
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  output logic [BLK_W-1:0] result_c
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign result_c[BLK_W-1-8*(4*c+r) -: 8] = state[BLK_W-1-8*(4*((c+r)%4)+r) -: 8];
    end
  end

endmodule

// File: rtl/sub_bytes.sv
// SubBytes: byte-wise S-box substitution over a 128-bit state.
module sub_bytes
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  output logic [BLK_W-1:0] result_c
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign result_c[8*i +: 8] = sbox(state[8*i +: 8]);
  end

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryption controller: one shared round datapath, on-the-fly key schedule.
module aes_enc_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] plaintext,
  input  logic [BLK_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] ciphertext,
  output logic             busy
);

  if (NR != NR_AES128) begin : g_nr_check
    $error("aes_enc_ctrl: only NR=10 (AES-128) is supported");
  end

  aes_fsm_e         fsm_q;
  logic [BLK_W-1:0] state_q;
  logic [BLK_W-1:0] rk_q;
  logic [RND_W-1:0] rnd_q;

  logic [BLK_W-1:0] round_c;
  logic [BLK_W-1:0] fin_sb_c;
  logic [BLK_W-1:0] fin_sr_c;
  logic [BLK_W-1:0] ke_key_c;
  logic [RND_W-1:0] ke_idx_c;
  logic [BLK_W-1:0] ke_next_c;

  // The single key-expansion step seeds from the cipher key at accept, then chains on rk_q.
  assign ke_key_c = (fsm_q == IDLE) ? key : rk_q;
  assign ke_idx_c = (fsm_q == IDLE) ? RND_W'(1) : rnd_q + RND_W'(1);

  key_expand_step u_key (.round_key(ke_key_c), .rc(rcon(ke_idx_c)), .next_key_c(ke_next_c));
  enc_round       u_round (.state(state_q), .round_key(rk_q), .result_c(round_c));
  sub_bytes       u_fin_sb (.state(state_q), .result_c(fin_sb_c));
  shift_rows      u_fin_sr (.state(fin_sb_c), .result_c(fin_sr_c));

  assign ciphertext = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      rk_q      <= '0;
      rnd_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_q  <= plaintext ^ key;
            rk_q     <= ke_next_c;
            rnd_q    <= RND_W'(1);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            fsm_q    <= ROUND;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ROUND: begin
          state_q <= round_c;
          rk_q    <= ke_next_c;
          rnd_q   <= rnd_q + RND_W'(1);
          if (rnd_q == RND_W'(NR - 1)) fsm_q <= FINAL;
        end
        FINAL: begin
          state_q   <= fin_sr_c ^ rk_q;
          out_valid <= 1'b1;
          fsm_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            fsm_q     <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Self-checking bench for aes_enc_ctrl against a GF(2^8)-derived AES-128 reference model.
module tb_aes_enc_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  logic [7:0] sb [256];

  aes_enc_ctrl #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) w[i] = 32'(k >> (32 * (3 - i)));
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = 8'(pt >> (8 * (15 - i))) ^ 8'(k >> (8 * (15 - i)));
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[rw + 4*c] = s[rw + 4*((c + rw) % 4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
        for (int j = 0; j < 4; j++) s[4*c+j] = s[4*c+j] ^ 8'(w[4*rd+c] >> (8 * (3 - j)));
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], s[i]};
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 128'(in_ready), 128'(1));
  endtask

  // Accept one block, optionally scramble inputs while busy, stall the output bp cycles.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp, input bit scramble, input int bp);
    int n;
    logic [127:0] held;
    wait_ready(tag);
    plaintext = pt; key = k; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    chk({tag, "_in_ready_low"}, 128'(in_ready), 128'(0));
    n = 0;
    while (!out_valid && n < 40) begin
      if (scramble) begin
        plaintext = rnd128(); key = rnd128();
      end
      tick();
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(10));
    chk({tag, "_ct"}, ciphertext, exp);
    held = ciphertext;
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      plaintext = rnd128(); key = rnd128();
      tick();
      chk({tag, "_bp_ct"}, ciphertext, held);
      chk({tag, "_bp_in_ready"}, 128'(in_ready), 128'(0));
      chk({tag, "_bp_out_valid"}, 128'(out_valid), 128'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_hs_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_hs_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_hs_busy"}, 128'(busy), 128'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] pt, k, ct_b2b [2];
    int unsigned acc0, acc1;
    int n_out, n_acc;
    logic prev_busy;

    build_sbox();

    // Reset state
    tick(); tick(); tick();
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ct", ciphertext, 128'(0));
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", 128'(in_ready), 128'(1));

    // Known-answer vectors; B also scrambles inputs and stalls the output
    run_block("c1", C1_PT, C1_KEY, C1_CT, 1'b0, 0);
    run_block("fipsb", B_PT, B_KEY, B_CT, 1'b1, 20);
    chk("fipsb_rk10", dut.rk_q, B_RK10);

    // Back-to-back with in_valid/out_ready tied high
    plaintext = C1_PT; key = C1_KEY; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    acc0 = cyc; acc1 = 0;
    chk("b2b_busy0", 128'(busy), 128'(1));
    plaintext = B_PT; key = B_KEY;
    n_out = 0; n_acc = 1; prev_busy = 1'b1;
    ct_b2b[0] = '0; ct_b2b[1] = '0;
    for (int i = 0; i < 40 && n_out < 2; i++) begin
      tick();
      if (busy && !prev_busy) begin
        acc1 = cyc; n_acc++; in_valid = 1'b0;
      end
      if (out_valid) begin
        ct_b2b[n_out] = ciphertext; n_out++;
      end
      prev_busy = busy;
    end
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("b2b_ct0", ct_b2b[0], C1_CT);
    chk("b2b_ct1", ct_b2b[1], B_CT);
    chk("b2b_accepts", 128'(n_acc), 128'(2));
    chk("b2b_spacing", 128'(acc1 - acc0), 128'(12));
    chk("b2b_idle", 128'(in_ready), 128'(1));

    // Randomized blocks against the reference model
    for (int i = 0; i < 6; i++) begin
      pt = rnd128(); k = rnd128();
      run_block("rand", pt, k, aes_ref(pt, k), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Reset mid-block
    wait_ready("rst_mid");
    plaintext = C1_PT; key = C1_KEY; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_in_ready", 128'(in_ready), 128'(0));
    chk("rstm_out_valid", 128'(out_valid), 128'(0));
    chk("rstm_busy", 128'(busy), 128'(0));
    chk("rstm_ct", ciphertext, 128'(0));
    tick(); tick();
    chk("rstm_held_out_valid", 128'(out_valid), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("rstm_rel_in_ready", 128'(in_ready), 128'(1));
    run_block("c1_after_rst", C1_PT, C1_KEY, C1_CT, 1'b1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
